board_store: RTL and testbench

- Parametrised successor to the top-level board register array.
- Holds the ROWS x COLS board of PIECE_W-bit squares and drives the flattened board bus to logic and display.
- Adds four functions: a timed initial-position load sequencer, atomic two-square move commit with a valid/ready handshake, a bounded undo history, and a direct single-square write port.

---
 rtl/chess_pkg.sv | 53 +++++
 rtl/board_store_if.sv | 45 ++++
 rtl/board_store_undo_lifo.sv | 55 +++++
 rtl/board_store.sv | 136 +++++++++++++
 tb/tb_board_store.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: piece encodings, board FSM states and the initial-position function
// shared by the board store and its history buffer.
`default_nettype none

package chess_pkg;

  localparam logic [2:0] PT_EMPTY  = 3'd0;
  localparam logic [2:0] PT_PAWN   = 3'd1;
  localparam logic [2:0] PT_KNIGHT = 3'd2;
  localparam logic [2:0] PT_BISHOP = 3'd3;
  localparam logic [2:0] PT_ROOK   = 3'd4;
  localparam logic [2:0] PT_QUEEN  = 3'd5;
  localparam logic [2:0] PT_KING   = 3'd6;
  localparam logic       COLOR_WHITE = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Colour lands in bit piece_w-1; only the standard 8-column layout is populated.
  function automatic logic [31:0] init_piece(input int row, input int col,
                                             input int rows, input int cols,
                                             input int piece_w);
    logic [2:0]  t;
    logic        white;
    logic [31:0] v;
    t     = PT_EMPTY;
    white = ~COLOR_WHITE;
    v     = '0;
    if (cols == 8 && rows >= 4) begin
      if (row == 0 || row == rows - 1) begin
        case (col)
          0, 7:    t = PT_ROOK;
          1, 6:    t = PT_KNIGHT;
          2, 5:    t = PT_BISHOP;
          3:       t = PT_QUEEN;
          default: t = PT_KING;
        endcase
      end else if (row == 1 || row == rows - 2) begin
        t = PT_PAWN;
      end
      white = (row <= 1) ? COLOR_WHITE : ~COLOR_WHITE;
    end
    if (t != PT_EMPTY) begin
      v = 32'(t) | (32'(white) << (piece_w - 1));
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_store_if.sv
// board_store_if: request, handshake and status signals between a board client
// (master) and the board store (slave).
`default_nettype none

interface board_store_if #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int PIECE_W    = 4,
  parameter int UNDO_DEPTH = 16
);
  localparam int ADDR_W = $clog2(ROWS * COLS);
  localparam int CNT_W  = $clog2(UNDO_DEPTH + 1);

  logic                         init_req;
  logic                         mv_valid;
  logic                         mv_ready;
  logic [ADDR_W-1:0]            mv_from;
  logic [ADDR_W-1:0]            mv_to;
  logic [PIECE_W-1:0]           mv_piece;
  logic                         undo_req;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [PIECE_W-1:0]           wr_piece;
  logic [ROWS*COLS*PIECE_W-1:0] board_flat;
  logic                         busy;
  logic                         init_done;
  logic [PIECE_W-1:0]           captured;
  logic [CNT_W-1:0]             undo_count;
  logic                         err;

  modport master (
    output init_req, mv_valid, mv_from, mv_to, mv_piece, undo_req,
           wr_en, wr_addr, wr_piece,
    input  mv_ready, board_flat, busy, init_done, captured, undo_count, err
  );

  modport slave (
    input  init_req, mv_valid, mv_from, mv_to, mv_piece, undo_req,
           wr_en, wr_addr, wr_piece,
    output mv_ready, board_flat, busy, init_done, captured, undo_count, err
  );

endinterface

`default_nettype wire

// File: rtl/board_store_undo_lifo.sv
// undo_lifo: ring-buffer LIFO of move records; a push when full overwrites the
// oldest entry, a pop when empty only raises underflow.
`default_nettype none

module undo_lifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[top] <= din;
    end
  end

  // top wraps naturally, so the oldest slot is the one reused once full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
    end else if (clr) begin
      top   <= '0;
      count <= '0;
    end else if (push) begin
      top <= top + 1'b1;
      if (count != CNT_W'(DEPTH)) begin
        count <= count + 1'b1;
      end
    end else if (pop && count != '0) begin
      top   <= top - 1'b1;
      count <= count - 1'b1;
    end
  end

  assign dout      = mem[top - 1'b1];
  assign underflow = pop && (count == '0);

endmodule

`default_nettype wire

// File: rtl/board_store.sv
// board_store: ROWS x COLS board register array with initial-position loader,
// handshaked move commit, undo history and direct square writes.
`default_nettype none

module board_store #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int PIECE_W    = 4,
  parameter int UNDO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  board_store_if.slave bus
);
  import chess_pkg::*;

  localparam int NSQ    = ROWS * COLS;
  localparam int ADDR_W = $clog2(NSQ);
  localparam int CNT_W  = $clog2(UNDO_DEPTH + 1);
  localparam int HIST_W = 2 * ADDR_W + 2 * PIECE_W;

  state_t             state;
  logic [ADDR_W-1:0]  load_idx;
  logic [PIECE_W-1:0] board [NSQ];
  logic               busy_r, ready_r, done_r, err_r;
  logic [PIECE_W-1:0] cap_r;

  logic               idle, do_init, do_undo, do_move, do_wr;
  logic               hist_push, hist_underflow;
  logic [HIST_W-1:0]  hist_din, hist_dout;
  logic [CNT_W-1:0]   hist_count;
  logic [ADDR_W-1:0]  h_from, h_to;
  logic [PIECE_W-1:0] h_sf, h_st;

  always_comb begin
    idle      = (state == ST_IDLE);
    do_init   = idle && bus.init_req;
    do_undo   = idle && !bus.init_req && bus.undo_req;
    do_move   = idle && !bus.init_req && !bus.undo_req && bus.mv_valid;
    do_wr     = idle && !bus.init_req && !bus.undo_req && !bus.mv_valid && bus.wr_en;
    hist_push = do_move && (bus.mv_from != bus.mv_to);
    hist_din  = {bus.mv_from, bus.mv_to, board[bus.mv_from], board[bus.mv_to]};
    {h_from, h_to, h_sf, h_st} = hist_dout;
  end

  undo_lifo #(
    .DEPTH (UNDO_DEPTH),
    .W     (HIST_W),
    .CNT_W (CNT_W)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr       (do_init),
    .push      (hist_push),
    .pop       (do_undo),
    .din       (hist_din),
    .dout      (hist_dout),
    .count     (hist_count),
    .underflow (hist_underflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      load_idx <= '0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      cap_r    <= '0;
      for (int i = 0; i < NSQ; i++) begin
        board[i] <= PIECE_W'(init_piece(i / COLS, i % COLS, ROWS, COLS, PIECE_W));
      end
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_init) begin
            state    <= ST_LOAD;
            load_idx <= '0;
            busy_r   <= 1'b1;
            ready_r  <= 1'b0;
          end else if (do_undo) begin
            if (hist_underflow) begin
              err_r <= 1'b1;
            end else begin
              board[h_from] <= h_sf;
              board[h_to]   <= h_st;
            end
          end else if (do_move) begin
            if (bus.mv_from == bus.mv_to) begin
              err_r <= 1'b1;
            end else begin
              board[bus.mv_to]   <= bus.mv_piece;
              board[bus.mv_from] <= '0;
              cap_r              <= board[bus.mv_to];
            end
          end else if (do_wr) begin
            board[bus.wr_addr] <= bus.wr_piece;
          end
        end
        ST_LOAD: begin
          board[load_idx] <= PIECE_W'(init_piece(int'(load_idx) / COLS,
                                                 int'(load_idx) % COLS,
                                                 ROWS, COLS, PIECE_W));
          if (load_idx == ADDR_W'(NSQ - 1)) begin
            state   <= ST_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b1;
          end else begin
            load_idx <= load_idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Ready drops in the same cycle a higher-priority request arrives, so a move
  // that loses arbitration is never seen as accepted by the master.
  assign bus.mv_ready   = ready_r && !bus.init_req && !bus.undo_req;
  assign bus.busy       = busy_r;
  assign bus.init_done  = done_r;
  assign bus.err        = err_r;
  assign bus.captured   = cap_r;
  assign bus.undo_count = hist_count;

  for (genvar i = 0; i < NSQ; i++) begin : g_flat
    assign bus.board_flat[i*PIECE_W +: PIECE_W] = board[i];
  end

endmodule

`default_nettype wire

// File: tb/tb_board_store.sv
// tb_board_store: directed self-checking bench for board_store (8x8, 4-bit
// squares, 4-entry history) against hand-computed board states.
`default_nettype none

module tb_board_store;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_store_if #(.ROWS(8), .COLS(8), .PIECE_W(4), .UNDO_DEPTH(4)) bus ();

  board_store #(.ROWS(8), .COLS(8), .PIECE_W(4), .UNDO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [255:0] rp;
  logic [255:0] m;
  logic [255:0] snap;
  logic [3:0]   back [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [3:0] sq(input int i);
    return bus.board_flat[i*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input int from, input int to, input logic [3:0] p);
    bus.mv_valid = 1'b1;
    bus.mv_from  = 6'(from);
    bus.mv_to    = 6'(to);
    bus.mv_piece = p;
    tick();
    bus.mv_valid = 1'b0;
  endtask

  task automatic undo();
    bus.undo_req = 1'b1;
    tick();
    bus.undo_req = 1'b0;
  endtask

  initial begin
    int busyc, bad, donec, e;
    int froms [6];

    bus.init_req = 0; bus.mv_valid = 0; bus.mv_from = 0; bus.mv_to = 0;
    bus.mv_piece = 0; bus.undo_req = 0; bus.wr_en = 0; bus.wr_addr = 0;
    bus.wr_piece = 0;

    back = '{4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4};
    rp = '0;
    for (int c = 0; c < 8; c++) begin
      rp[c*4 +: 4]        = 4'h8 | back[c];
      rp[(8 + c)*4 +: 4]  = 4'h9;
      rp[(48 + c)*4 +: 4] = 4'h1;
      rp[(56 + c)*4 +: 4] = back[c];
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_sq12", 256'(sq(12)), 256'(4'h9));
    chk("reset_sq4", 256'(sq(4)), 256'(4'hE));
    chk("reset_sq60", 256'(sq(60)), 256'(4'h6));
    chk("reset_sq28", 256'(sq(28)), 256'(4'h0));
    chk("reset_board", bus.board_flat, rp);
    chk("reset_undo_count", 256'(bus.undo_count), 256'(0));
    chk("reset_mv_ready", 256'(bus.mv_ready), 256'(1));
    chk("reset_busy", 256'(bus.busy), 256'(0));
    m = rp;

    // simple move and undo
    bus.mv_valid = 1'b1; bus.mv_from = 6'd12; bus.mv_to = 6'd28; bus.mv_piece = 4'h9;
    #1 chk("move_ready", 256'(bus.mv_ready), 256'(1));
    tick();
    bus.mv_valid = 1'b0;
    chk("move_sq28", 256'(sq(28)), 256'(4'h9));
    chk("move_sq12", 256'(sq(12)), 256'(4'h0));
    chk("move_captured", 256'(bus.captured), 256'(0));
    chk("move_count", 256'(bus.undo_count), 256'(1));
    undo();
    chk("undo_sq12", 256'(sq(12)), 256'(4'h9));
    chk("undo_sq28", 256'(sq(28)), 256'(4'h0));
    chk("undo_count0", 256'(bus.undo_count), 256'(0));
    chk("undo_board", bus.board_flat, rp);

    // direct write, capture, undo, underflow
    bus.wr_en = 1'b1; bus.wr_addr = 6'd28; bus.wr_piece = 4'h1;
    tick();
    bus.wr_en = 1'b0;
    m[28*4 +: 4] = 4'h1;
    chk("wr_sq28", 256'(sq(28)), 256'(4'h1));
    chk("wr_count", 256'(bus.undo_count), 256'(0));
    move(12, 28, 4'h9);
    chk("cap_captured", 256'(bus.captured), 256'(4'h1));
    chk("cap_sq28", 256'(sq(28)), 256'(4'h9));
    undo();
    chk("cap_undo_sq28", 256'(sq(28)), 256'(4'h1));
    chk("cap_undo_sq12", 256'(sq(12)), 256'(4'h9));
    chk("cap_undo_err", 256'(bus.err), 256'(0));
    undo();
    chk("underflow_err", 256'(bus.err), 256'(1));
    chk("underflow_board", bus.board_flat, m);
    tick();
    chk("err_pulse_clear", 256'(bus.err), 256'(0));

    // same-square move is accepted but rejected
    move(12, 12, 4'h5);
    chk("same_sq_err", 256'(bus.err), 256'(1));
    chk("same_sq_board", bus.board_flat, m);
    chk("same_sq_count", 256'(bus.undo_count), 256'(0));

    // history ring saturation with depth 4
    froms = '{8, 9, 10, 11, 13, 14};
    for (int i = 0; i < 6; i++) begin
      move(froms[i], froms[i] + 8, 4'h9);
      m[froms[i]*4 +: 4]       = 4'h0;
      m[(froms[i] + 8)*4 +: 4] = 4'h9;
      e = (i + 1 > 4) ? 4 : i + 1;
      chk($sformatf("ring_count_%0d", i), 256'(bus.undo_count), 256'(e));
      if (i == 1) snap = m;
    end
    chk("ring_board", bus.board_flat, m);
    for (int i = 0; i < 4; i++) begin
      undo();
      chk($sformatf("ring_undo_err_%0d", i), 256'(bus.err), 256'(0));
    end
    chk("ring_restored", bus.board_flat, snap);
    chk("ring_count_empty", 256'(bus.undo_count), 256'(0));
    undo();
    chk("ring_fifth_undo_err", 256'(bus.err), 256'(1));
    chk("ring_fifth_board", bus.board_flat, snap);

    // reload mid-game, stray requests ignored
    move(50, 42, 4'h1);
    chk("pre_load_count", 256'(bus.undo_count), 256'(1));
    bus.init_req = 1'b1;
    tick();
    bus.init_req = 1'b0;
    busyc = 0; bad = 0; donec = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.busy) begin
        busyc++;
        if (bus.mv_ready !== 1'b0) bad++;
      end
      if (bus.init_done) donec++;
      bus.mv_valid = (busyc >= 40 && busyc < 50);
      bus.wr_en    = (busyc >= 40 && busyc < 50);
      bus.undo_req = (busyc >= 40 && busyc < 50);
      bus.mv_from = 6'd2; bus.mv_to = 6'd5; bus.mv_piece = 4'h5;
      bus.wr_addr = 6'd3; bus.wr_piece = 4'h0;
      tick();
    end
    bus.mv_valid = 0; bus.wr_en = 0; bus.undo_req = 0;
    chk("load_busy_cycles", 256'(busyc), 256'(64));
    chk("load_ready_low", 256'(bad), 256'(0));
    chk("load_done_pulses", 256'(donec), 256'(1));
    chk("load_board", bus.board_flat, rp);
    chk("load_count", 256'(bus.undo_count), 256'(0));
    chk("load_no_err", 256'(bus.err), 256'(0));

    // simultaneous init/undo/move, then async reset mid-load
    move(12, 20, 4'h9);
    chk("pre_sim_count", 256'(bus.undo_count), 256'(1));
    bus.init_req = 1'b1; bus.undo_req = 1'b1; bus.mv_valid = 1'b1;
    bus.mv_from = 6'd11; bus.mv_to = 6'd27; bus.mv_piece = 4'h9;
    #1 chk("sim_mv_ready", 256'(bus.mv_ready), 256'(0));
    tick();
    bus.init_req = 0; bus.undo_req = 0; bus.mv_valid = 0;
    chk("sim_busy", 256'(bus.busy), 256'(1));
    chk("sim_no_undo_sq20", 256'(sq(20)), 256'(4'h9));
    chk("sim_no_move_sq27", 256'(sq(27)), 256'(4'h0));
    chk("sim_count", 256'(bus.undo_count), 256'(0));
    repeat (20) tick();
    chk("mid_load_sq20", 256'(sq(20)), 256'(4'h9));
    rst = 1'b1;
    #1;
    chk("async_rst_board", bus.board_flat, rp);
    chk("async_rst_busy", 256'(bus.busy), 256'(0));
    chk("async_rst_ready", 256'(bus.mv_ready), 256'(1));
    #3 rst = 1'b0;
    tick();
    chk("post_rst_busy", 256'(bus.busy), 256'(0));
    chk("post_rst_board", bus.board_flat, rp);
    chk("post_rst_done", 256'(bus.init_done), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
